// File: rtl/mcu_shared_ram.sv
// Shared 4 KB RAM between the main CPU (16-bit word port) and the sample MCU
// (8-bit external RAM port). Two 2048x8 byte banks, one arbitration FSM.
// The MCU has priority. A CPU write to the mailbox byte raises the MCU
// interrupt, and an MCU write to the acknowledge byte drops it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access in flight; MCU pending wins over CPU request
// M_ISSUE | MCU address/data driven into its bank (write happens here)
// M_DATA  | MCU bank read data captured into ext_ram_din; pending cleared
// C_ISSUE | CPU word address driven into both banks (byte-lane writes)
// C_DATA  | CPU read word captured; ack registered for next cycle
// C_DONE  | ack visible; CPU request ignored while requester releases it

module mcu_shared_ram #(
  parameter logic [11:0] MBOX_ADDR = 12'hFFE,
  parameter logic [11:0] ACK_ADDR  = 12'hFFF
) (
  input  logic        CLK_32M,
  input  logic        reset,
  input  logic [11:0] ext_ram_addr,
  input  logic [7:0]  ext_ram_dout,
  input  logic        ext_ram_cs,
  input  logic        ext_ram_we,
  output logic [7:0]  ext_ram_din,
  output logic        ext_ram_int,
  input  logic [10:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic [1:0]  cpu_be,
  input  logic        cpu_we,
  input  logic        cpu_req,
  output logic [15:0] cpu_dout,
  output logic        cpu_ack
);

  typedef enum logic [2:0] {
    IDLE,
    M_ISSUE,
    M_DATA,
    C_ISSUE,
    C_DATA,
    C_DONE
  } state_t;

  state_t state;
  state_t state_next;

  // MCU request capture
  logic        cs_q;
  logic        cs_rise;
  logic        mcu_pend;
  logic [11:0] mcu_addr;
  logic [7:0]  mcu_data;
  logic        mcu_we;

  // Bank ports
  logic [7:0]  ram_even [0:2047];
  logic [7:0]  ram_odd  [0:2047];
  logic        ram_en;
  logic [10:0] ram_addr;
  logic [7:0]  wdata_even;
  logic [7:0]  wdata_odd;
  logic        we_even;
  logic        we_odd;
  logic [7:0]  q_even;
  logic [7:0]  q_odd;

  // Mailbox events, each only possible in its own FSM state
  logic        mbox_set;
  logic        mbox_clr;

  assign cs_rise = ext_ram_cs & ~cs_q;

  assign mbox_set = (state == C_ISSUE) && cpu_we &&
                    (cpu_addr == MBOX_ADDR[11:1]) && cpu_be[MBOX_ADDR[0]];
  assign mbox_clr = (state == M_ISSUE) && mcu_we && (mcu_addr == ACK_ADDR);

  // Latch one MCU access per rising edge of cs; a new capture overrides the clear
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      cs_q     <= 1'b0;
      mcu_pend <= 1'b0;
      mcu_addr <= 12'h000;
      mcu_data <= 8'h00;
      mcu_we   <= 1'b0;
    end else begin
      cs_q <= ext_ram_cs;
      if (cs_rise) begin
        mcu_pend <= 1'b1;
        mcu_addr <= ext_ram_addr;
        mcu_data <= ext_ram_dout;
        mcu_we   <= ext_ram_we;
      end else if (state == M_DATA) begin
        mcu_pend <= 1'b0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: MCU first, CPU second, CPU request ignored in C_DONE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mcu_pend) begin
          state_next = M_ISSUE;
        end else if (cpu_req) begin
          state_next = C_ISSUE;
        end
      end
      M_ISSUE: state_next = M_DATA;
      M_DATA:  state_next = IDLE;
      C_ISSUE: state_next = C_DATA;
      C_DATA:  state_next = C_DONE;
      C_DONE:  state_next = mcu_pend ? M_ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bank port steering: MCU drives one bank, CPU drives both with byte enables
  always_comb begin
    ram_en     = 1'b0;
    ram_addr   = 11'h000;
    wdata_even = 8'h00;
    wdata_odd  = 8'h00;
    we_even    = 1'b0;
    we_odd     = 1'b0;
    case (state)
      M_ISSUE: begin
        ram_en     = 1'b1;
        ram_addr   = mcu_addr[11:1];
        wdata_even = mcu_data;
        wdata_odd  = mcu_data;
        we_even    = mcu_we & ~mcu_addr[0];
        we_odd     = mcu_we &  mcu_addr[0];
      end
      C_ISSUE: begin
        ram_en     = 1'b1;
        ram_addr   = cpu_addr;
        wdata_even = cpu_din[7:0];
        wdata_odd  = cpu_din[15:8];
        we_even    = cpu_we & cpu_be[0];
        we_odd     = cpu_we & cpu_be[1];
      end
      default: begin
        ram_en = 1'b0;
      end
    endcase
  end

  // Even byte bank, single port, read-before-write, contents survive reset
  always_ff @(posedge CLK_32M) begin
    if (ram_en) begin
      if (we_even) begin
        ram_even[ram_addr] <= wdata_even;
      end
      q_even <= ram_even[ram_addr];
    end
  end

  // Odd byte bank, same organisation as the even bank
  always_ff @(posedge CLK_32M) begin
    if (ram_en) begin
      if (we_odd) begin
        ram_odd[ram_addr] <= wdata_odd;
      end
      q_odd <= ram_odd[ram_addr];
    end
  end

  // Registered read data, CPU ack pulse and mailbox interrupt
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      ext_ram_din <= 8'h00;
      cpu_dout    <= 16'h0000;
      cpu_ack     <= 1'b0;
      ext_ram_int <= 1'b0;
    end else begin
      cpu_ack <= (state == C_DATA);
      if ((state == M_DATA) && !mcu_we) begin
        ext_ram_din <= mcu_addr[0] ? q_odd : q_even;
      end
      if ((state == C_DATA) && !cpu_we) begin
        cpu_dout <= {q_odd, q_even};
      end
      if (mbox_set) begin
        ext_ram_int <= 1'b1;
      end else if (mbox_clr) begin
        ext_ram_int <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mcu_shared_ram.sv
// Bench for mcu_shared_ram: directed scenarios plus random traffic checked
// against a byte-array model of the shared RAM and the mailbox flag.

module tb_mcu_shared_ram;

  localparam logic [11:0] MBOX = 12'hFFE;
  localparam logic [11:0] ACK  = 12'hFFF;

  logic        CLK_32M;
  logic        reset;
  logic [11:0] ext_ram_addr;
  logic [7:0]  ext_ram_dout;
  logic        ext_ram_cs;
  logic        ext_ram_we;
  logic [7:0]  ext_ram_din;
  logic        ext_ram_int;
  logic [10:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [1:0]  cpu_be;
  logic        cpu_we;
  logic        cpu_req;
  logic [15:0] cpu_dout;
  logic        cpu_ack;

  mcu_shared_ram #(.MBOX_ADDR(MBOX), .ACK_ADDR(ACK)) dut (
    .CLK_32M      (CLK_32M),
    .reset        (reset),
    .ext_ram_addr (ext_ram_addr),
    .ext_ram_dout (ext_ram_dout),
    .ext_ram_cs   (ext_ram_cs),
    .ext_ram_we   (ext_ram_we),
    .ext_ram_din  (ext_ram_din),
    .ext_ram_int  (ext_ram_int),
    .cpu_addr     (cpu_addr),
    .cpu_din      (cpu_din),
    .cpu_be       (cpu_be),
    .cpu_we       (cpu_we),
    .cpu_req      (cpu_req),
    .cpu_dout     (cpu_dout),
    .cpu_ack      (cpu_ack)
  );

  initial CLK_32M = 1'b0;
  always #5 CLK_32M = ~CLK_32M;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [7:0] model_mem [4096];
  logic       model_int;
  logic [7:0] model_din;

  logic [15:0] rd;
  logic [7:0]  rb;
  int          lat;

  // Model-side effects of a CPU write
  task automatic model_cpu_write(input logic [10:0] a, input logic [15:0] d, input logic [1:0] be);
    if (be[0]) model_mem[{a, 1'b0}] = d[7:0];
    if (be[1]) model_mem[{a, 1'b1}] = d[15:8];
    if ((a == MBOX[11:1]) && be[MBOX[0]]) model_int = 1'b1;
  endtask

  // Model-side effects of an MCU access
  task automatic model_mcu(input logic we, input logic [11:0] a, input logic [7:0] d);
    if (we) begin
      model_mem[a] = d;
      if (a == ACK) model_int = 1'b0;
    end else begin
      model_din = model_mem[a];
    end
  endtask

  // One CPU access from an idle block; returns edges until ack and the data
  task automatic cpu_op(input logic we, input logic [10:0] a, input logic [15:0] d,
                        input logic [1:0] be, output logic [15:0] dout, output int l);
    @(negedge CLK_32M);
    cpu_addr = a; cpu_din = d; cpu_be = be; cpu_we = we; cpu_req = 1'b1;
    l = -1;
    dout = 16'h0000;
    for (int k = 0; k < 20 && l < 0; k++) begin
      @(posedge CLK_32M); #1;
      if (cpu_ack) begin
        l = k;
        dout = cpu_dout;
      end
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    if (l < 0) begin
      n_checks++; n_fail++;
      $display("FAIL cpu_ack_timeout: no ack within 20 cycles for addr %h", a);
    end
    @(posedge CLK_32M);
    if (we) model_cpu_write(a, d, be);
  endtask

  // One MCU access: cs held for 'hold' cycles, then idle until serviced
  task automatic mcu_op(input logic we, input logic [11:0] a, input logic [7:0] d,
                        input int hold, output logic [7:0] din);
    @(negedge CLK_32M);
    ext_ram_addr = a; ext_ram_dout = d; ext_ram_we = we; ext_ram_cs = 1'b1;
    repeat (hold) @(negedge CLK_32M);
    ext_ram_cs = 1'b0;
    ext_ram_we = 1'b0;
    repeat (4) @(negedge CLK_32M);
    din = ext_ram_din;
    model_mcu(we, a, d);
  endtask

  function automatic logic [10:0] window_row(input int i);
    return (i < 16) ? 11'(i) : 11'(11'h7F8 + 11'(i - 16));
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge CLK_32M);
    #1;
    n_checks++;
    if (ext_ram_din !== 8'h00) begin n_fail++; $display("FAIL reset_din: got %h want 00", ext_ram_din); end
    n_checks++;
    if (ext_ram_int !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b want 0", ext_ram_int); end
    n_checks++;
    if (cpu_dout !== 16'h0000) begin n_fail++; $display("FAIL reset_cpu_dout: got %h want 0000", cpu_dout); end
    n_checks++;
    if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ack: got %b want 0", cpu_ack); end
    @(negedge CLK_32M);
    reset = 1'b0;
    model_int = 1'b0;
    model_din = 8'h00;
    repeat (2) @(posedge CLK_32M);
  endtask

  task automatic test_cpu_to_mcu();
    cpu_op(1'b1, 11'h091, 16'hBEEF, 2'b11, rd, lat);
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL cpu_write_latency: got %0d want 2", lat); end
    mcu_op(1'b0, 12'h122, 8'h00, 4, rb);
    n_checks++;
    if (rb !== 8'hEF) begin n_fail++; $display("FAIL mcu_read_even: got %h want EF", rb); end
    mcu_op(1'b0, 12'h123, 8'h00, 4, rb);
    n_checks++;
    if (rb !== 8'hBE) begin n_fail++; $display("FAIL mcu_read_odd: got %h want BE", rb); end
  endtask

  task automatic test_mcu_to_cpu();
    mcu_op(1'b1, 12'h000, 8'h5A, 4, rb);
    cpu_op(1'b0, 11'h000, 16'h0000, 2'b11, rd, lat);
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL cpu_read_latency: got %0d want 2", lat); end
    n_checks++;
    if (rd[7:0] !== 8'h5A) begin n_fail++; $display("FAIL cpu_read_low: got %h want 5A", rd[7:0]); end
  endtask

  task automatic test_mcu_timing();
    logic [7:0] d;
    logic [7:0] old;
    d = model_din ^ 8'hA5;
    old = model_din;
    cpu_op(1'b1, 11'h008, {8'h00, d}, 2'b01, rd, lat);
    @(negedge CLK_32M);
    ext_ram_addr = 12'h010; ext_ram_we = 1'b0; ext_ram_cs = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK_32M); #1;
      if (k == 2) begin
        n_checks++;
        if (ext_ram_din !== old) begin n_fail++; $display("FAIL mcu_din_early: got %h want %h", ext_ram_din, old); end
      end
      if (k == 3) begin
        n_checks++;
        if (ext_ram_din !== d) begin n_fail++; $display("FAIL mcu_din_cycle3: got %h want %h", ext_ram_din, d); end
      end
    end
    ext_ram_cs = 1'b0;
    model_mcu(1'b0, 12'h010, 8'h00);
    repeat (3) @(negedge CLK_32M);
  endtask

  task automatic test_mailbox();
    mcu_op(1'b1, 12'hFFF, 8'h77, 4, rb);
    @(negedge CLK_32M);
    cpu_addr = 11'h7FF; cpu_din = 16'h1234; cpu_be = 2'b01; cpu_we = 1'b1; cpu_req = 1'b1;
    @(posedge CLK_32M); #1;
    n_checks++;
    if (ext_ram_int !== 1'b0) begin n_fail++; $display("FAIL mbox_int_early: got %b want 0", ext_ram_int); end
    @(posedge CLK_32M); #1;
    n_checks++;
    if (ext_ram_int !== 1'b1) begin n_fail++; $display("FAIL mbox_int_rise: got %b want 1", ext_ram_int); end
    @(posedge CLK_32M); #1;
    n_checks++;
    if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL mbox_ack: got %b want 1", cpu_ack); end
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(posedge CLK_32M);
    model_cpu_write(11'h7FF, 16'h1234, 2'b01);

    mcu_op(1'b0, 12'hFFE, 8'h00, 4, rb);
    n_checks++;
    if (rb !== 8'h34) begin n_fail++; $display("FAIL mbox_byte: got %h want 34", rb); end
    mcu_op(1'b0, 12'hFFF, 8'h00, 4, rb);
    n_checks++;
    if (rb !== 8'h77) begin n_fail++; $display("FAIL ack_byte_kept: got %h want 77", rb); end
    n_checks++;
    if (ext_ram_int !== 1'b1) begin n_fail++; $display("FAIL int_after_mcu_read: got %b want 1", ext_ram_int); end
    mcu_op(1'b1, 12'hFFF, 8'h99, 4, rb);
    n_checks++;
    if (ext_ram_int !== 1'b0) begin n_fail++; $display("FAIL int_clear: got %b want 0", ext_ram_int); end
    mcu_op(1'b0, 12'hFFE, 8'h00, 4, rb);
    n_checks++;
    if (ext_ram_int !== 1'b0) begin n_fail++; $display("FAIL int_read_stays: got %b want 0", ext_ram_int); end
    cpu_op(1'b1, 11'h7FF, 16'hAB00, 2'b10, rd, lat);
    n_checks++;
    if (ext_ram_int !== 1'b0) begin n_fail++; $display("FAIL int_odd_lane: got %b want 0", ext_ram_int); end
  endtask

  task automatic test_worst_case();
    logic [7:0]  d;
    logic [15:0] cdat;
    int          ack_k;
    d = model_din ^ 8'h5A;
    cpu_op(1'b1, 11'h020, 16'hCAFE, 2'b11, rd, lat);
    mcu_op(1'b1, 12'h003, d, 4, rb);
    cdat = {model_mem[12'h041], model_mem[12'h040]};
    ack_k = -1;
    @(negedge CLK_32M);
    cpu_addr = 11'h020; cpu_we = 1'b0; cpu_be = 2'b11; cpu_req = 1'b1;
    ext_ram_addr = 12'h003; ext_ram_we = 1'b0; ext_ram_cs = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK_32M); #1;
      if (cpu_ack && ack_k < 0) begin
        ack_k = k;
        rd = cpu_dout;
        cpu_req = 1'b0;
      end
      if (k == 3) ext_ram_cs = 1'b0;
      if (k == 5) begin
        n_checks++;
        if (ext_ram_din !== d) begin n_fail++; $display("FAIL worst_mcu_din: got %h want %h", ext_ram_din, d); end
      end
    end
    cpu_req = 1'b0;
    model_mcu(1'b0, 12'h003, 8'h00);
    n_checks++;
    if (ack_k != 2) begin n_fail++; $display("FAIL worst_cpu_ack_cycle: got %0d want 2", ack_k); end
    n_checks++;
    if (rd !== cdat) begin n_fail++; $display("FAIL worst_cpu_data: got %h want %h", rd, cdat); end
  endtask

  task automatic test_random();
    int errs;
    for (int i = 0; i < 24; i++) begin
      cpu_op(1'b1, window_row(i), 16'($urandom), 2'b11, rd, lat);
    end
    for (int n = 0; n < 120; n++) begin
      int          op;
      logic [10:0] row;
      logic [11:0] ba;
      logic [7:0]  d8;
      logic [15:0] d16;
      logic [1:0]  be;
      logic [15:0] exp16;
      op  = int'($urandom_range(0, 3));
      row = window_row(int'($urandom_range(0, 23)));
      ba  = {row, 1'($urandom_range(0, 1))};
      d8  = 8'($urandom);
      d16 = 16'($urandom);
      be  = 2'($urandom_range(0, 3));
      case (op)
        0: begin
          cpu_op(1'b1, row, d16, be, rd, lat);
          n_checks++;
          if (lat != 2 || ext_ram_int !== model_int) begin
            n_fail++;
            $display("FAIL rnd_cpu_write: lat %0d int %b want lat 2 int %b", lat, ext_ram_int, model_int);
          end
        end
        1: begin
          exp16 = {model_mem[{row, 1'b1}], model_mem[{row, 1'b0}]};
          cpu_op(1'b0, row, 16'h0000, 2'b11, rd, lat);
          n_checks++;
          if (lat != 2 || rd !== exp16) begin
            n_fail++;
            $display("FAIL rnd_cpu_read: row %h lat %0d got %h want lat 2 data %h", row, lat, rd, exp16);
          end
        end
        2: begin
          mcu_op(1'b1, ba, d8, 4, rb);
          n_checks++;
          if (ext_ram_int !== model_int) begin
            n_fail++;
            $display("FAIL rnd_mcu_write_int: addr %h got %b want %b", ba, ext_ram_int, model_int);
          end
        end
        default: begin
          mcu_op(1'b0, ba, 8'h00, 4, rb);
          n_checks++;
          if (rb !== model_din) begin
            n_fail++;
            $display("FAIL rnd_mcu_read: addr %h got %h want %h", ba, rb, model_din);
          end
        end
      endcase
    end
    errs = 0;
  endtask

  task automatic test_be_zero();
    logic [15:0] exp16;
    exp16 = {model_mem[12'h00B], model_mem[12'h00A]};
    cpu_op(1'b1, 11'h005, ~exp16, 2'b00, rd, lat);
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL be0_ack: got latency %0d want 2", lat); end
    cpu_op(1'b0, 11'h005, 16'h0000, 2'b11, rd, lat);
    n_checks++;
    if (rd !== exp16) begin n_fail++; $display("FAIL be0_unchanged: got %h want %h", rd, exp16); end
  endtask

  task automatic test_cs_hold();
    @(negedge CLK_32M);
    ext_ram_addr = 12'h014; ext_ram_dout = 8'hAA; ext_ram_we = 1'b1; ext_ram_cs = 1'b1;
    repeat (4) @(posedge CLK_32M);
    model_mcu(1'b1, 12'h014, 8'hAA);
    cpu_op(1'b1, 11'h00A, 16'h0055, 2'b01, rd, lat);
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL hold_cpu_latency: got %0d want 2", lat); end
    repeat (2) @(posedge CLK_32M);
    @(negedge CLK_32M);
    ext_ram_cs = 1'b0; ext_ram_we = 1'b0;
    repeat (6) @(negedge CLK_32M);
    cpu_op(1'b0, 11'h00A, 16'h0000, 2'b11, rd, lat);
    n_checks++;
    if (rd[7:0] !== model_mem[12'h014]) begin
      n_fail++; $display("FAIL hold_single_access: got %h want %h", rd[7:0], model_mem[12'h014]);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp_a;
    logic [15:0] exp_m;
    cpu_op(1'b1, 11'h7FF, 16'h00C3, 2'b01, rd, lat);
    mcu_op(1'b0, 12'h014, 8'h00, 4, rb);
    exp_a = {model_mem[12'h015], model_mem[12'h014]};
    exp_m = {model_mem[12'hFFF], model_mem[12'hFFE]};
    @(negedge CLK_32M);
    cpu_addr = 11'h00A; cpu_we = 1'b0; cpu_be = 2'b11; cpu_req = 1'b1;
    @(posedge CLK_32M); #1;
    @(posedge CLK_32M); #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (cpu_ack !== 1'b0 || cpu_dout !== 16'h0000) begin
      n_fail++; $display("FAIL midreset_cpu: ack %b dout %h want 0 0000", cpu_ack, cpu_dout);
    end
    n_checks++;
    if (ext_ram_din !== 8'h00 || ext_ram_int !== 1'b0) begin
      n_fail++; $display("FAIL midreset_mcu: din %h int %b want 00 0", ext_ram_din, ext_ram_int);
    end
    repeat (2) @(posedge CLK_32M);
    #1;
    n_checks++;
    if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL midreset_no_ack: got %b want 0", cpu_ack); end
    cpu_req = 1'b0;
    @(negedge CLK_32M);
    reset = 1'b0;
    model_int = 1'b0;
    model_din = 8'h00;
    repeat (3) @(posedge CLK_32M);
    #1;
    n_checks++;
    if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL postreset_no_ack: got %b want 0", cpu_ack); end
    cpu_op(1'b0, 11'h00A, 16'h0000, 2'b11, rd, lat);
    n_checks++;
    if (rd !== exp_a) begin n_fail++; $display("FAIL ram_retained: got %h want %h", rd, exp_a); end
    cpu_op(1'b0, 11'h7FF, 16'h0000, 2'b11, rd, lat);
    n_checks++;
    if (rd !== exp_m) begin n_fail++; $display("FAIL mbox_retained: got %h want %h", rd, exp_m); end
  endtask

  initial begin
    reset = 1'b1;
    ext_ram_addr = '0; ext_ram_dout = '0; ext_ram_cs = 1'b0; ext_ram_we = 1'b0;
    cpu_addr = '0; cpu_din = '0; cpu_be = '0; cpu_we = 1'b0; cpu_req = 1'b0;
    model_int = 1'b0;
    model_din = 8'h00;
    for (int i = 0; i < 4096; i++) model_mem[i] = 8'h00;
    test_reset();
    test_cpu_to_mcu();
    test_mcu_to_cpu();
    test_mcu_timing();
    test_mailbox();
    test_worst_case();
    test_random();
    test_be_zero();
    test_cs_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
